// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and slice width.
// Optional subtract mode is enabled by defining NSADD_SUB_EN (see the interface and top).
package nibble_serial_add_ctrl_pkg;
   localparam int NIB_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Host-side handshake and operand/result bundle for nibble_serial_add_ctrl.
// Defining NSADD_SUB_EN adds the 'sub' request bit.
interface nibble_serial_add_ctrl_if #(
   parameter int NIBBLES = 4
);
   import nibble_serial_add_ctrl_pkg::*;
   localparam int W = NIB_W * NIBBLES;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
`ifdef NSADD_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         c_out;
   logic         ovf;

   modport master (
      output start, a, b, c_in,
`ifdef NSADD_SUB_EN
      output sub,
`endif
      input  busy, done, s, c_out, ovf
   );

   modport slave (
      input  start, a, b, c_in,
`ifdef NSADD_SUB_EN
      input  sub,
`endif
      output busy, done, s, c_out, ovf
   );
endinterface

// File: rtl/nibble_adder.sv
// 4-bit combinational ripple-carry slice built from full adders.
module nibble_adder
   import nibble_serial_add_ctrl_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             c_in,
   output logic [NIB_W-1:0] s,
   output logic             c_out
);
   logic [NIB_W:0] cy;

   assign cy[0] = c_in;

   for (genvar i = 0; i < NIB_W; i++) begin : g_fa
      assign s[i]    = a[i] ^ b[i] ^ cy[i];
      assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
   end

   assign c_out = cy[NIB_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer adding two W-bit operands one nibble per clock through a single slice.
// Defining NSADD_SUB_EN enables a - b via inverted B and forced carry-in.
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input logic                      clk,
   input logic                      rst,
   nibble_serial_add_ctrl_if.slave  bus
);
   localparam int W     = NIB_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   logic [1:0]       state;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;
   logic [W-1:0]     s_r;
   logic             carry_reg;
   logic             c_out_r;
   logic             ovf_r;
   logic [IDX_W-1:0] idx;

   logic [NIB_W-1:0] nib_a;
   logic [NIB_W-1:0] nib_b;
   logic [NIB_W-1:0] nib_s;
   logic             nib_c;
   logic             accept;
   logic             sub_req;
   logic [W-1:0]     b_eff;
   logic             cin_eff;

`ifdef NSADD_SUB_EN
   assign sub_req = bus.sub;
`else
   assign sub_req = 1'b0;
`endif

   assign accept  = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
   assign b_eff   = sub_req ? ~bus.b : bus.b;
   assign cin_eff = sub_req ? 1'b1 : bus.c_in;

   assign nib_a = op_a[idx*NIB_W +: NIB_W];
   assign nib_b = op_b[idx*NIB_W +: NIB_W];

   nibble_adder u_slice (
      .a     (nib_a),
      .b     (nib_b),
      .c_in  (carry_reg),
      .s     (nib_s),
      .c_out (nib_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_a      <= '0;
         op_b      <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         s_r       <= '0;
         c_out_r   <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               s_r[idx*NIB_W +: NIB_W] <= nib_s;
               carry_reg               <= nib_c;
               idx                     <= idx + IDX_W'(1);
               // Top nibble: its sign bit is the fresh slice output, not yet in s_r.
               if (idx == IDX_LAST) begin
                  state   <= ST_DONE;
                  c_out_r <= nib_c;
                  ovf_r   <= (op_a[W-1] == op_b[W-1]) && (nib_s[NIB_W-1] != op_a[W-1]);
               end
            end
            default: begin
               if (accept) begin
                  state     <= ST_RUN;
                  op_a      <= bus.a;
                  op_b      <= b_eff;
                  carry_reg <= cin_eff;
                  idx       <= '0;
                  s_r       <= '0;
                  c_out_r   <= 1'b0;
                  ovf_r     <= 1'b0;
               end else if (state == ST_DONE) begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy  = (state == ST_RUN);
   assign bus.done  = (state == ST_DONE);
   assign bus.s     = s_r;
   assign bus.c_out = c_out_r;
   assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized bench for nibble_serial_add_ctrl with an arithmetic reference model.
// Subtract cases run only when NSADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;
   localparam int N = 4;
   localparam int W = 4 * N;
`ifdef NSADD_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic sub_drv;

   always #5 clk = ~clk;

   nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();
`ifdef NSADD_SUB_EN
   assign bus.sub = sub_drv;
`endif

   nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: {ovf, c_out, sum} from plain integer arithmetic.
   function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
      longint ux   = longint'(x);
      longint uy   = longint'(y);
      longint sx   = longint'($signed(x));
      longint sy   = longint'($signed(y));
      longint smax = (longint'(1) << (W - 1)) - 1;
      longint smin = -(longint'(1) << (W - 1));
      longint u;
      longint sv;
      logic   cy;
      logic   ov;
      if (sb) begin
         u  = ux - uy;
         sv = sx - sy;
         cy = (ux >= uy);
      end else begin
         u  = ux + uy + longint'(ci);
         sv = sx + sy + longint'(ci);
         cy = (u >= (longint'(1) << W));
      end
      ov = (sv > smax) || (sv < smin);
      return {ov, cy, u[W-1:0]};
   endfunction

   function automatic logic [W-1:0] low_mask(input int nibs);
      return W'((longint'(1) << (4 * nibs)) - 1);
   endfunction

   // Model: age 0 idle, 1..N running, N+1 done.
   int           m_age = 0;
   logic [W+1:0] m_res = '0;
   logic [W-1:0] m_s   = '0;
   logic         m_c   = 1'b0;
   logic         m_o   = 1'b0;
   bit           armed = 1'b0;

   always @(posedge clk) begin
      armed <= 1'b1;
      if (rst) begin
         m_age <= 0;
         m_s   <= '0;
         m_c   <= 1'b0;
         m_o   <= 1'b0;
      end else if ((m_age == 0 || m_age == N + 1) && bus.start) begin
         m_res <= ref_op(bus.a, bus.b, bus.c_in, sub_drv);
         m_age <= 1;
         m_s   <= '0;
         m_c   <= 1'b0;
         m_o   <= 1'b0;
      end else if (m_age >= 1 && m_age <= N) begin
         m_age <= m_age + 1;
         if (m_age == N) begin
            m_s <= m_res[W-1:0];
            m_c <= m_res[W];
            m_o <= m_res[W+1];
         end else begin
            m_s <= m_res[W-1:0] & low_mask(m_age);
         end
      end else if (m_age == N + 1) begin
         m_age <= 0;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("busy",  32'(bus.busy),  32'(m_age >= 1 && m_age <= N));
         check("done",  32'(bus.done),  32'(m_age == N + 1));
         check("s",     32'(bus.s),     32'(m_s));
         check("c_out", 32'(bus.c_out), 32'(m_c));
         check("ovf",   32'(bus.ovf),   32'(m_o));
      end
   end

   // Called at a negedge; returns at the negedge where done is visible.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input logic sb, output int edges, output int busy_n);
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      bus.c_in  = ci;
      sub_drv   = sb;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.c_in  = 1'($urandom);
      edges     = 1;
      busy_n    = 0;
      while (!bus.done && edges < 20) begin
         if (bus.busy) busy_n++;
         @(negedge clk);
         edges++;
      end
      check("done_reached", 32'(bus.done), 32'd1);
   endtask

   initial begin
      int e;
      int bn;
      int dn;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.c_in  = 1'b0;
      sub_drv   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_s",    32'(bus.s),    32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, e, bn);
      check("basic_s",       32'(bus.s),     32'h5555);
      check("basic_c_out",   32'(bus.c_out), 32'd0);
      check("basic_ovf",     32'(bus.ovf),   32'd0);
      check("basic_busy_n",  32'(bn),        32'd4);
      check("basic_latency", 32'(e),         32'd5);
      @(negedge clk);

      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, e, bn);
      check("carry_s",     32'(bus.s),     32'h0000);
      check("carry_c_out", 32'(bus.c_out), 32'd1);
      check("carry_ovf",   32'(bus.ovf),   32'd0);
      @(negedge clk);

      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, e, bn);
      check("ovf_s",     32'(bus.s),     32'h8000);
      check("ovf_c_out", 32'(bus.c_out), 32'd0);
      check("ovf_ovf",   32'(bus.ovf),   32'd1);
      @(negedge clk);

      // Start re-asserted with new operands while running must be ignored.
      bus.start = 1'b1; bus.a = 16'h0102; bus.b = 16'h0304; bus.c_in = 1'b0; sub_drv = 1'b0;
      @(negedge clk);
      bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.c_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done) dn++;
         @(negedge clk);
      end
      check("ign_s",      32'(bus.s), 32'h0406);
      check("ign_dones",  32'(dn),    32'd1);

      // Reset after two nibbles have been written.
      bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.c_in = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("partial_s", 32'(bus.s), 32'h0033);
      rst = 1'b1;
      @(negedge clk);
      check("rrun_s",    32'(bus.s),    32'd0);
      check("rrun_busy", 32'(bus.busy), 32'd0);
      check("rrun_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_op(16'h0A0A, 16'h0505, 1'b1, 1'b0, e, bn);
      check("after_rst_s", 32'(bus.s), 32'h0F10);

      // Back-to-back: start held into the done cycle.
      run_op(16'h0001, 16'h0001, 1'b1, 1'b0, e, bn);
      check("b2b_s",       32'(bus.s), 32'h0003);
      check("b2b_latency", 32'(e),     32'd5);
      @(negedge clk);

      if (HAS_SUB) begin
         run_op(16'h0005, 16'h0007, 1'b0, 1'b1, e, bn);
         check("sub_s",     32'(bus.s),     32'hFFFE);
         check("sub_c_out", 32'(bus.c_out), 32'd0);
         run_op(16'h0001, 16'h0001, 1'b0, 1'b0, e, bn);
         check("sub_b2b_s",       32'(bus.s), 32'h0002);
         check("sub_b2b_latency", 32'(e),     32'd5);
         @(negedge clk);
      end

      for (int i = 0; i < 40; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom),
                HAS_SUB ? 1'($urandom) : 1'b0, e, bn);
         check("rnd_latency", 32'(e), 32'd5);
         if ($urandom_range(0, 2) != 0) @(negedge clk);
      end

      @(negedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
